// File: rtl/cmos_fusion_blend.sv
// Dual-camera RGB565 alpha blender: per-camera FWFT alignment FIFOs restarted on vsync, 2-stage blend.
// Latency 2 cycles from the pop of a pixel pair; no backpressure, so writes to a full FIFO are dropped and flagged.
module cmos_fusion_fifo #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        wr,
  input  logic [15:0] wdat,
  input  logic        pop,
  output logic [15:0] rdat,
  output logic        empty,
  output logic        ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          full, do_pop, do_wr;

  assign empty  = (cnt == '0);
  assign full   = (cnt == (AW+1)'(DEPTH));
  assign do_pop = pop && !empty && !flush;
  // a pop frees the slot in the same cycle, so write+pop on a full FIFO succeeds
  assign do_wr  = wr && !flush && (!full || do_pop);
  assign ovf    = wr && !flush && full && !do_pop;
  assign rdat   = mem[rp];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_wr)  wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= wdat;
  end
endmodule

module cmos_fusion_blend #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        cmos0_vsync,
  input  logic        cmos0_valid,
  input  logic [15:0] cmos0_data,
  input  logic        cmos1_vsync,
  input  logic        cmos1_valid,
  input  logic [15:0] cmos1_data,
  input  logic [4:0]  alpha,
  output logic        fusion_valid,
  output logic [15:0] fusion_data,
  output logic        fusion_sof,
  output logic [1:0]  ovf_flag
);
  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_RUN} state_t;

  state_t      state;
  logic        vs0_q, vs1_q, seen0, seen1, sof_pending;
  logic        edge0, edge1, flush, pop, empty0, empty1, ovf0, ovf1;
  logic [15:0] rd0, rd1;
  logic [4:0]  a_w, ia_w;
  logic        s1_vld, s1_sof;
  logic [8:0]  r0p, r1p, b0p, b1p, sum_r, sum_b;
  logic [9:0]  g0p, g1p, sum_g;

  assign edge0 = cmos0_vsync & ~vs0_q;
  assign edge1 = cmos1_vsync & ~vs1_q;

  always_comb begin
    flush = 1'b0;
    case (state)
      S_ALIGN: flush = (seen0 | edge0) & (seen1 | edge1);
      S_RUN:   flush = edge0 | edge1;
      default: flush = 1'b0;
    endcase
  end

  assign pop = !empty0 && !empty1 && !flush;

  cmos_fusion_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk(sys_clk), .rst_n(sys_rst_n), .flush(flush),
    .wr(cmos0_valid && state == S_RUN), .wdat(cmos0_data),
    .pop(pop), .rdat(rd0), .empty(empty0), .ovf(ovf0)
  );

  cmos_fusion_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk(sys_clk), .rst_n(sys_rst_n), .flush(flush),
    .wr(cmos1_valid && state == S_RUN), .wdat(cmos1_data),
    .pop(pop), .rdat(rd1), .empty(empty1), .ovf(ovf1)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state       <= S_IDLE;
      vs0_q       <= 1'b0;
      vs1_q       <= 1'b0;
      seen0       <= 1'b0;
      seen1       <= 1'b0;
      sof_pending <= 1'b0;
      ovf_flag    <= 2'b00;
    end else begin
      vs0_q    <= cmos0_vsync;
      vs1_q    <= cmos1_vsync;
      ovf_flag <= ovf_flag | {ovf1, ovf0};
      if (pop) sof_pending <= 1'b0;
      case (state)
        S_IDLE: begin
          if (edge0 | edge1) begin
            seen0 <= edge0;
            seen1 <= edge1;
            state <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          if ((seen0 | edge0) & (seen1 | edge1)) begin
            seen0       <= 1'b0;
            seen1       <= 1'b0;
            sof_pending <= 1'b1;
            state       <= S_RUN;
          end else begin
            seen0 <= seen0 | edge0;
            seen1 <= seen1 | edge1;
          end
        end
        S_RUN: begin
          // both cameras restarting together realigns without passing through S_ALIGN
          if (edge0 & edge1) begin
            sof_pending <= 1'b1;
          end else if (edge0 | edge1) begin
            seen0 <= edge0;
            seen1 <= edge1;
            state <= S_ALIGN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign a_w   = (alpha > 5'd16) ? 5'd16 : alpha;
  assign ia_w  = 5'd16 - a_w;
  assign sum_r = r0p + r1p;
  assign sum_g = g0p + g1p;
  assign sum_b = b0p + b1p;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      s1_vld       <= 1'b0;
      s1_sof       <= 1'b0;
      r0p          <= '0;
      r1p          <= '0;
      g0p          <= '0;
      g1p          <= '0;
      b0p          <= '0;
      b1p          <= '0;
      fusion_valid <= 1'b0;
      fusion_sof   <= 1'b0;
      fusion_data  <= 16'h0000;
    end else begin
      s1_vld <= pop;
      s1_sof <= pop & sof_pending;
      if (pop) begin
        r0p <= 9'(rd0[15:11]) * 9'(a_w);
        r1p <= 9'(rd1[15:11]) * 9'(ia_w);
        g0p <= 10'(rd0[10:5]) * 10'(a_w);
        g1p <= 10'(rd1[10:5]) * 10'(ia_w);
        b0p <= 9'(rd0[4:0]) * 9'(a_w);
        b1p <= 9'(rd1[4:0]) * 9'(ia_w);
      end
      fusion_valid <= s1_vld;
      fusion_sof   <= s1_sof;
      if (s1_vld) fusion_data <= {sum_r[8:4], sum_g[9:4], sum_b[8:4]};
    end
  end
endmodule

// File: tb/tb_cmos_fusion_blend.sv
// Directed + randomized bench for cmos_fusion_blend; outputs scoreboarded against a pairing/arithmetic model.
module tb_cmos_fusion_blend;
  localparam int DEPTH = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        cmos0_vsync = 1'b0, cmos0_valid = 1'b0;
  logic [15:0] cmos0_data = '0;
  logic        cmos1_vsync = 1'b0, cmos1_valid = 1'b0;
  logic [15:0] cmos1_data = '0;
  logic [4:0]  alpha = 5'd8;
  logic        fusion_valid, fusion_sof;
  logic [15:0] fusion_data;
  logic [1:0]  ovf_flag;

  always #5 sys_clk = ~sys_clk;

  cmos_fusion_blend #(.FIFO_DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmos0_vsync(cmos0_vsync), .cmos0_valid(cmos0_valid), .cmos0_data(cmos0_data),
    .cmos1_vsync(cmos1_vsync), .cmos1_valid(cmos1_valid), .cmos1_data(cmos1_data),
    .alpha(alpha), .fusion_valid(fusion_valid), .fusion_data(fusion_data),
    .fusion_sof(fusion_sof), .ovf_flag(ovf_flag)
  );

  typedef struct {logic [15:0] d; logic sof;} exp_t;

  int          checks = 0, errors = 0, n_out = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] m0[$], m1[$];
  bit          model_run = 1'b0, sof_exp = 1'b0;
  logic [1:0]  ovf_exp = 2'b00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] blend(input logic [15:0] p0, input logic [15:0] p1, input logic [4:0] al);
    int a, x, y, r, g, b;
    x = int'(p0);
    y = int'(p1);
    a = (al > 5'd16) ? 16 : int'(al);
    r = ((x / 2048) * a + (y / 2048) * (16 - a)) / 16;
    g = (((x / 32) % 64) * a + ((y / 32) % 64) * (16 - a)) / 16;
    b = ((x % 32) * a + (y % 32) * (16 - a)) / 16;
    return 16'(r * 2048 + g * 32 + b);
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Model: pixels accepted while aligned queue per camera; the i-th pixels of each camera pair up in order.
  task automatic px(input bit v0, input logic [15:0] d0, input bit v1, input logic [15:0] d1);
    exp_t e;
    cmos0_valid = v0; cmos0_data = d0;
    cmos1_valid = v1; cmos1_data = d1;
    if (model_run) begin
      if (v0) begin if (m0.size() < DEPTH) m0.push_back(d0); else ovf_exp[0] = 1'b1; end
      if (v1) begin if (m1.size() < DEPTH) m1.push_back(d1); else ovf_exp[1] = 1'b1; end
      while (m0.size() > 0 && m1.size() > 0) begin
        e.d = blend(m0.pop_front(), m1.pop_front(), alpha);
        e.sof = sof_exp;
        sof_exp = 1'b0;
        exp_q.push_back(e);
      end
    end
    tick();
    cmos0_valid = 1'b0;
    cmos1_valid = 1'b0;
  endtask

  task automatic align_both();
    model_run = 1'b0;
    m0.delete(); m1.delete();
    cmos0_vsync = 1'b1; cmos1_vsync = 1'b1;
    repeat (4) tick();
    cmos0_vsync = 1'b0; cmos1_vsync = 1'b0;
    tick();
    model_run = 1'b1;
    sof_exp = 1'b1;
  endtask

  always @(negedge sys_clk) begin
    if (fusion_valid === 1'b1) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'(fusion_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pix_data", 32'(fusion_data), 32'(mon_e.d));
        check("pix_sof", 32'(fusion_sof), 32'(mon_e.sof));
      end
    end
  end

  initial begin
    logic [15:0] hold_exp [3];
    logic [4:0]  alist [3];
    int sent0, sent1, nb;
    hold_exp[0] = 16'h1234; hold_exp[1] = 16'hABCD; hold_exp[2] = 16'h1234;
    alist[0] = 5'd16; alist[1] = 5'd0; alist[2] = 5'd20;

    repeat (3) tick();
    check("rst_valid", 32'(fusion_valid), 32'd0);
    check("rst_sof", 32'(fusion_sof), 32'd0);
    check("rst_data", 32'(fusion_data), 32'h0);
    check("rst_ovf", 32'(ovf_flag), 32'd0);
    sys_rst_n = 1'b1;
    tick();

    // same-cycle vsync on both cameras, then one pair
    alpha = 5'd8;
    align_both();
    px(1'b1, 16'hF800, 1'b1, 16'h001F);
    tick();
    check("lat_early_valid", 32'(fusion_valid), 32'd0);
    tick();
    check("lat_valid", 32'(fusion_valid), 32'd1);
    check("lat_data", 32'(fusion_data), 32'h780F);
    check("lat_sof", 32'(fusion_sof), 32'd1);

    // alpha extremes and clamping
    for (int i = 0; i < 3; i++) begin
      alpha = alist[i];
      tick();
      px(1'b1, 16'h1234, 1'b1, 16'hABCD);
      repeat (4) tick();
      check("alpha_hold_data", 32'(fusion_data), 32'(hold_exp[i]));
      check("alpha_hold_valid", 32'(fusion_valid), 32'd0);
    end

    // randomized traffic, camera skew bounded to stay below FIFO depth
    sent0 = 0; sent1 = 0;
    for (int rnd = 0; rnd < 3; rnd++) begin
      alpha = 5'($urandom_range(0, 20));
      repeat (2) tick();
      for (int c = 0; c < 30; c++) begin
        bit v0, v1;
        v0 = ($urandom % 2 == 1) && (sent0 - sent1 < 8);
        v1 = ($urandom % 2 == 1) && (sent1 - sent0 < 8);
        if (v0) sent0++;
        if (v1) sent1++;
        px(v0, 16'($urandom), v1, 16'($urandom));
      end
      while (sent0 != sent1) begin
        if (sent0 > sent1) begin px(1'b0, 16'h0, 1'b1, 16'($urandom)); sent1++; end
        else begin px(1'b1, 16'($urandom), 1'b0, 16'h0); sent0++; end
      end
      repeat (5) tick();
      check("rand_drain", 32'(exp_q.size()), 32'd0);
    end
    check("rand_ovf", 32'(ovf_flag), 32'd0);

    // overflow of camera 0, then camera 1 drains exactly the 16 buffered pixels
    alpha = 5'd5;
    repeat (2) tick();
    for (int i = 0; i < 17; i++) px(1'b1, 16'($urandom), 1'b0, 16'h0);
    tick();
    check("ovf_flag_cam0", 32'(ovf_flag), 32'(ovf_exp));
    nb = n_out;
    for (int i = 0; i < 16; i++) px(1'b0, 16'h0, 1'b1, 16'($urandom));
    repeat (5) tick();
    check("ovf_out_count", 32'(n_out - nb), 32'd16);
    check("ovf_drain", 32'(exp_q.size()), 32'd0);

    // camera-0 vsync while 3 pixels sit in FIFO 0 and one pair is in the blend pipeline
    alpha = 5'd11;
    px(1'b1, 16'($urandom), 1'b0, 16'h0);
    px(1'b1, 16'($urandom), 1'b0, 16'h0);
    px(1'b1, 16'($urandom), 1'b0, 16'h0);
    px(1'b1, 16'($urandom), 1'b1, 16'($urandom));
    tick();
    model_run = 1'b0;
    m0.delete(); m1.delete();
    cmos0_vsync = 1'b1;
    repeat (5) tick();
    check("inflight_emitted", 32'(exp_q.size()), 32'd0);
    nb = n_out;
    for (int i = 0; i < 3; i++) px(1'b1, 16'($urandom), 1'b1, 16'($urandom));
    repeat (4) tick();
    check("align_drop", 32'(n_out - nb), 32'd0);
    cmos1_vsync = 1'b1;
    tick();
    cmos0_vsync = 1'b0; cmos1_vsync = 1'b0;
    tick();

    // camera-1 vsync 5 cycles after camera-0, pixels in between
    cmos0_vsync = 1'b1;
    nb = n_out;
    for (int i = 0; i < 5; i++) px(1'b1, 16'($urandom), 1'b1, 16'($urandom));
    cmos1_vsync = 1'b1;
    tick();
    model_run = 1'b1; sof_exp = 1'b1;
    m0.delete(); m1.delete();
    tick();
    check("skew_no_early_out", 32'(n_out - nb), 32'd0);
    alpha = 5'd7;
    px(1'b1, 16'($urandom), 1'b1, 16'($urandom));
    repeat (4) tick();
    check("skew_one_out", 32'(n_out - nb), 32'd1);
    cmos0_vsync = 1'b0; cmos1_vsync = 1'b0;
    tick();

    // reset pulse mid-stream with pixels buffered and in flight
    model_run = 1'b0;
    px(1'b1, 16'hFFFF, 1'b1, 16'hFFFF);
    px(1'b1, 16'hFFFF, 1'b1, 16'hFFFF);
    sys_rst_n = 1'b0;
    px(1'b1, 16'hFFFF, 1'b1, 16'hFFFF);
    check("mrst_valid", 32'(fusion_valid), 32'd0);
    check("mrst_sof", 32'(fusion_sof), 32'd0);
    check("mrst_data", 32'(fusion_data), 32'h0);
    check("mrst_ovf", 32'(ovf_flag), 32'd0);
    sys_rst_n = 1'b1;
    nb = n_out;
    tick();
    check("mrst_release_valid", 32'(fusion_valid), 32'd0);
    px(1'b1, 16'hFFFF, 1'b1, 16'hFFFF);
    px(1'b1, 16'hFFFF, 1'b1, 16'hFFFF);
    repeat (4) tick();
    check("mrst_no_out", 32'(n_out - nb), 32'd0);
    alpha = 5'd3;
    align_both();
    px(1'b1, 16'($urandom), 1'b1, 16'($urandom));
    repeat (4) tick();
    check("final_drain", 32'(exp_q.size()), 32'd0);
    check("final_out_count", 32'(n_out - nb), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
